// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a two-entry skid buffer.
// Accepts {pc, instr} over valid/ready, decodes the register fields, the
// sign-extended immediate and the register-usage flags, and hands one entry
// per cycle to execute. in_ready comes straight from a flop. flush drops
// everything in flight.
// Optional feature: define DECODE_ILLEGAL_EN to add the registered 'illegal' output.

package decode_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            rs1_en,
  output logic            rs2_en,
`ifdef DECODE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic            rd_we
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t      dec;
  logic [31:0] imm32;
  logic        use_rd, use_rs1, use_rs2;

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire;

  // Combinational decode of the incoming instruction into a full entry.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    imm32   = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (in_instr[6:0])
      OP_R: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        use_rd = 1'b1;
        imm32  = {in_instr[31:12], 12'b0};
      end
      default: ;  // unknown opcode: no register use, imm stays 0
    endcase

    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = use_rd  ? in_instr[11:7]  : 5'd0;
    dec.rs1    = use_rs1 ? in_instr[19:15] : 5'd0;
    dec.rs2    = use_rs2 ? in_instr[24:20] : 5'd0;
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    dec.imm    = XLEN'($signed(imm32));
    dec.rs1_en = use_rs1;
    dec.rs2_en = use_rs2;
    dec.rd_we  = use_rd && (in_instr[11:7] != 5'd0);
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = !(in_instr[6:0] inside {OP_R, OP_I, OP_LOAD, OP_S, OP_B,
                                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
               || (in_instr[1:0] != 2'b11)
               || ((in_instr[6:0] == OP_R) &&
                   !(in_instr[31:25] inside {7'b0000000, 7'b0100000}));
`endif
  end

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;

  // Next-state for the output register and the skid register.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot is empty or draining: refill from skid first, else from input.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled: park the new entry in the skid register.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset has priority over flush and over every transfer.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the data registers are reset as well, because outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign imm       = out_q.imm;
  assign rs1_en    = out_q.rs1_en;
  assign rs2_en    = out_q.rs2_en;
  assign rd_we     = out_q.rd_we;
`ifdef DECODE_ILLEGAL_EN
  assign illegal   = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed cases plus a randomized valid/ready/flush
// stream, all checked against a queue-based reference model.
module tb_decode_stage;

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                     7'b0010111};

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rs1_en, rs2_en, rd_we, illegal;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        rs1_en, rs2_en, rd_we;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .rs1_en(rs1_en), .rs2_en(rs2_en),
`ifdef DECODE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .rd_we(rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode, computed from the format rules with integer arithmetic.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    int   v = 0;
    bit   ur = 0, u1 = 0, u2 = 0, known = 1;
    case (ins[6:0])
      7'b0110011: begin ur = 1; u1 = 1; u2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        ur = 1; u1 = 1; v = $signed(ins[31:20]);
      end
      7'b0100011: begin u1 = 1; u2 = 1; v = $signed({ins[31:25], ins[11:7]}); end
      7'b1100011: begin
        u1 = 1; u2 = 1;
        v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]});
        v = v * 2;
      end
      7'b1101111: begin
        ur = 1;
        v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]});
        v = v * 2;
      end
      7'b0110111, 7'b0010111: begin ur = 1; v = int'(ins[31:12]) * 4096; end
      default: known = 0;
    endcase
    e.pc      = pc;
    e.opcode  = ins[6:0];
    e.rd      = ur ? ins[11:7] : 5'd0;
    e.rs1     = u1 ? ins[19:15] : 5'd0;
    e.rs2     = u2 ? ins[24:20] : 5'd0;
    e.funct3  = ins[14:12];
    e.funct7  = ins[31:25];
    e.imm     = v;
    e.rs1_en  = u1;
    e.rs2_en  = u2;
    e.rd_we   = ur && (ins[11:7] != 0);
    e.illegal = !known || (ins[1:0] != 2'b11) ||
                (ins[6:0] == 7'b0110011 && ins[31:25] != 7'h00 && ins[31:25] != 7'h20);
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      e = q[0];
      check("out_pc", out_pc, e.pc);
      check("opcode", opcode, e.opcode);
      check("rd", rd, e.rd);
      check("rs1", rs1, e.rs1);
      check("rs2", rs2, e.rs2);
      check("funct3", funct3, e.funct3);
      check("funct7", funct7, e.funct7);
      check("imm", imm, e.imm);
      check("rs1_en", rs1_en, e.rs1_en);
      check("rs2_en", rs2_en, e.rs2_en);
      check("rd_we", rd_we, e.rd_we);
`ifdef DECODE_ILLEGAL_EN
      check("illegal", illegal, e.illegal);
`endif
    end
  endtask

  // One cycle: drive inputs (called just after a negedge), advance the model,
  // cross the rising edge, then compare on the following negedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit accept;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    accept    = v && (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (accept) q.push_back(model(pc, ins));
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 9);
    if (sel < 9) r[6:0] = OPS[sel];
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h40; in_instr = 32'hFFF08293;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state: in_valid was high throughout and must have been ignored.
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_imm", imm, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_rd", rd, 5'd0);
    rst = 1'b0;

    // addi x5,x1,-1
    step(1, 32'hFFF08293, 32'h100, 1, 0);
    check("addi_valid", out_valid, 1'b1);
    check("addi_rd", rd, 5'd5);
    check("addi_rs1", rs1, 5'd1);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_rd_we", rd_we, 1'b1);
    check("addi_rs2_en", rs2_en, 1'b0);
    check("addi_pc", out_pc, 32'h100);

    // beq x1,x2,-4
    step(1, 32'hFE208EE3, 32'h104, 1, 0);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_rd", rd, 5'd0);
    check("beq_rd_we", rd_we, 1'b0);
    check("beq_rs1_en", rs1_en, 1'b1);
    check("beq_rs2_en", rs2_en, 1'b1);

    // lui x3,0x12345
    step(1, 32'h123451B7, 32'h108, 1, 0);
    check("lui_imm", imm, 32'h12345000);
    check("lui_rs1_en", rs1_en, 1'b0);

    // jal x0,+8
    step(1, 32'h0080006F, 32'h10C, 1, 0);
    check("jal_imm", imm, 32'h8);
    check("jal_rd_we", rd_we, 1'b0);

`ifdef DECODE_ILLEGAL_EN
    step(1, 32'h00000000, 32'h110, 1, 0);
    check("ill_zero", illegal, 1'b1);
    step(1, 32'h023100B3, 32'h114, 1, 0);
    check("ill_funct7", illegal, 1'b1);
    step(1, 32'h003100B3, 32'h118, 1, 0);
    check("legal_add", illegal, 1'b0);
`endif
    step(0, 32'h0, 32'h0, 1, 0);

    // Stream four instructions while execute stalls: only two fit.
    for (int i = 0; i < 4; i++)
      step(1, 32'h00008013 | (32'(i + 1) << 7), 32'h200 + 32'(4 * i), 0, 0);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_pc", out_pc, 32'h200);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0);
    check("drained", out_valid, 1'b0);

    // Fill both registers, then flush with a same-cycle input.
    step(1, 32'h00108093, 32'h300, 0, 0);
    step(1, 32'h00210113, 32'h304, 0, 0);
    check("full_in_ready", in_ready, 1'b0);
    step(1, 32'h00318193, 32'h308, 0, 1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    step(0, 32'h0, 32'h0, 1, 0);
    check("flush_lost", out_valid, 1'b0);

    // Randomized traffic with back-pressure and occasional flushes.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
